rand_req_arbiter: RTL and testbench

//   Shares one 13-bit Fibonacci LFSR (taps 12,3,2,0) among NUM_REQ game-logic requesters.

---
 rtl/rand_pkg.sv | 26 ++
 rtl/lfsr13_core.sv | 40 ++++
 rtl/rand_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_rand_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared types and LFSR helpers for the random-number request arbiter.
// Used by lfsr13_core and rand_req_arbiter.
package rand_pkg;

  localparam int LFSR_W = 13;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MIX   = 2'd1,
    GRANT = 2'd2
  } rarb_state_t;

  // Next register value for one step. A zero state would lock up, so it reloads the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur,
                                                  input logic [LFSR_W-1:0] seed);
    logic [LFSR_W-1:0] nxt;
    if (cur == '0) begin
      nxt = seed;
    end else begin
      nxt = {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr13_core.sv
// 13-bit Fibonacci LFSR with step/load controls and a zero-state reload guard.
// The register updates on the rising clock edge; reset restores SEED asynchronously.
module lfsr13_core
  import rand_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 13'h000F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (q_q == '0) begin
      q_d = SEED;
    end else if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = lfsr_next(q_q, SEED);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rand_req_arbiter.sv
// Round-robin arbiter that hands out one LFSR value per grant, mixing SHIFTS steps first.
// Optional runtime reseeding is enabled by defining RAND_SEED_LOAD_EN.
module rand_req_arbiter
  import rand_pkg::*;
#(
  parameter int                NUM_REQ = 4,
  parameter int                SHIFTS  = 13,
  parameter logic [LFSR_W-1:0] SEED    = 13'h000F
) (
  input  logic               clock,
  input  logic               reset,
`ifdef RAND_SEED_LOAD_EN
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rnd_out,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CNT_LAST = 4'(SHIFTS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  rarb_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [LFSR_W-1:0] rnd_q, rnd_d;

  logic              lfsr_step;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_load_val;
  logic [LFSR_W-1:0] lfsr_q;

  logic              seed_load_w;
  logic [LFSR_W-1:0] seed_in_w;

`ifdef RAND_SEED_LOAD_EN
  assign seed_load_w = seed_load;
  assign seed_in_w   = seed_in;
`else
  assign seed_load_w = 1'b0;
  assign seed_in_w   = '0;
`endif

  // A zero seed would park the LFSR, so it falls back to the build-time seed.
  assign lfsr_load_val = (seed_in_w == '0) ? SEED : seed_in_w;

  lfsr13_core #(
    .SEED (SEED)
  ) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  logic             scan_hit;
  logic [PTR_W-1:0] scan_idx;
  int               scan_pos;

  // Descending walk so the closest set bit at or after ptr is the one that sticks.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = ptr_q;
    scan_pos = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_pos = int'(ptr_q) + i;
      if (scan_pos >= NUM_REQ) begin
        scan_pos = scan_pos - NUM_REQ;
      end
      if (req[scan_pos]) begin
        scan_hit = 1'b1;
        scan_idx = PTR_W'(scan_pos);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    rnd_d     = rnd_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seed_load_w) begin
          lfsr_load = 1'b1;
        end else if (scan_hit) begin
          win_d   = scan_idx;
          cnt_d   = 4'd0;
          state_d = MIX;
        end
      end
      MIX: begin
        lfsr_step = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          if (req[win_q]) begin
            // Capture the post-step value now so it is on rnd_out during the grant cycle.
            rnd_d   = lfsr_next(lfsr_q, SEED);
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT: begin
        ptr_d   = (win_q == PTR_LAST) ? '0 : PTR_W'(win_q + 1'b1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
      win_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == GRANT) begin
      gnt[win_q] = 1'b1;
    end
  end

  assign rnd_out = rnd_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Randomized scoreboard bench for rand_req_arbiter against a transaction-level model.
// A second instance with SHIFTS=1 walks the full LFSR period.
module tb_rand_req_arbiter;

  localparam int          NR   = 4;
  localparam int          SH   = 13;
  localparam logic [12:0] SEED = 13'h000F;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        rst1  = 1'b1;
  logic [3:0]  req   = '0;
  logic [3:0]  req1  = '0;
  logic [3:0]  gnt, gnt1;
  logic [12:0] rnd_out, rnd_out1;
  logic        busy, busy1;
`ifdef RAND_SEED_LOAD_EN
  logic        seed_load  = 1'b0;
  logic [12:0] seed_in    = '0;
  logic        seed_load1 = 1'b0;
  logic [12:0] seed_in1   = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rand_req_arbiter #(.NUM_REQ(NR), .SHIFTS(SH), .SEED(SEED)) dut (
    .clock     (clock),
    .reset     (rst),
`ifdef RAND_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_in   (seed_in),
`endif
    .req       (req),
    .gnt       (gnt),
    .rnd_out   (rnd_out),
    .busy      (busy)
  );

  rand_req_arbiter #(.NUM_REQ(NR), .SHIFTS(1), .SEED(SEED)) dut1 (
    .clock     (clock),
    .reset     (rst1),
`ifdef RAND_SEED_LOAD_EN
    .seed_load (seed_load1),
    .seed_in   (seed_in1),
`endif
    .req       (req1),
    .gnt       (gnt1),
    .rnd_out   (rnd_out1),
    .busy      (busy1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: the LFSR as a plain shift-with-parity rule, arbitration as a ring search.
  function automatic logic [12:0] mstep(input logic [12:0] x);
    return {x[11:0], x[12] ^ x[3] ^ x[2] ^ x[0]};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  g;
    logic [12:0] r;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] m_lfsr = SEED;
  int          m_ptr  = 0;

  // Called at a negedge inside an IDLE cycle; returns at a negedge inside the next IDLE cycle.
  task automatic txn(input logic [3:0] add, input int abort_k, input int poke_k);
    int   w;
    int   busy_n;
    exp_t e;
    req = req | add;
    if (req == 4'b0000) req = 4'b0001;
    w = rr_pick(req, m_ptr);
    for (int s = 0; s < SH; s++) m_lfsr = mstep(m_lfsr);
    if (abort_k < 0) begin
      e.g = 4'(1 << w);
      e.r = m_lfsr;
      e.c = cyc + SH + 1;
      exp_q.push_back(e);
    end
    busy_n = 0;
    for (int k = 0; k < SH; k++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (k == abort_k) req[w] = 1'b0;
`ifdef RAND_SEED_LOAD_EN
      seed_load = (k == poke_k);
      if (k == poke_k) seed_in = 13'($urandom);
`endif
    end
    @(negedge clock);
`ifdef RAND_SEED_LOAD_EN
    seed_load = 1'b0;
`endif
    if (busy) busy_n++;
    if (abort_k < 0) begin
      req[w] = 1'b0;
      m_ptr  = (w + 1) % NR;
    end
    chk("busy_cycles", busy_n, (abort_k < 0) ? SH + 1 : SH);
    if (abort_k < 0) @(negedge clock);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clock);
    rst    = 1'b0;
    m_lfsr = SEED;
    m_ptr  = 0;
    @(negedge clock);
  endtask

  // Scoreboard monitor: every grant must match the oldest outstanding expectation.
  initial begin
    logic [12:0] hold;
    exp_t        e;
    hold = '0;
    forever begin
      @(negedge clock);
      if (rst) begin
        hold = '0;
      end else if (gnt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", gnt, 4'b0000);
        end else begin
          e = exp_q.pop_front();
          chk("gnt", gnt, e.g);
          chk("rnd_out", rnd_out, e.r);
          chk("gnt_cycle", cyc, e.c);
          hold = e.r;
        end
      end else begin
        chk("rnd_hold", rnd_out, hold);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic main_seq();
    int ab;
    int pk;
    repeat (2) @(negedge clock);
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rnd", rnd_out, 13'h0);
    rst = 1'b0;
    @(negedge clock);

    txn(4'b0001, -1, -1);

    do_reset();
    txn(4'b1111, -1, -1);
    repeat (3) txn(4'b0000, -1, -1);
    txn(4'b0001, -1, -1);

    do_reset();
    txn(4'b0010, 5, -1);
    txn(4'b0011, -1, -1);
    txn(4'b0000, -1, -1);

    do_reset();
    req = 4'b0001;
    repeat (8) @(negedge clock);
    rst = 1'b1;
    #1;
    chk("midreset_gnt", gnt, 4'b0000);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_rnd", rnd_out, 13'h0);
    req = '0;
    @(negedge clock);
    rst    = 1'b0;
    m_lfsr = SEED;
    m_ptr  = 0;
    @(negedge clock);
    txn(4'b0001, -1, -1);

    for (int n = 0; n < 120; n++) begin
      if (req == 4'b0000 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clock);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, SH - 1)) : -1;
      pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SH - 1)) : -1;
      txn(4'($urandom_range(0, 15)), ab, pk);
    end
    while (req != 4'b0000) txn(4'b0000, -1, -1);

`ifdef RAND_SEED_LOAD_EN
    seed_load = 1'b1;
    seed_in   = 13'h1ABC;
    req       = 4'b0001;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr    = 13'h1ABC;
    txn(4'b0000, -1, -1);
    seed_load = 1'b1;
    seed_in   = 13'h0000;
    req       = 4'b0100;
    @(negedge clock);
    seed_load = 1'b0;
    m_lfsr    = SEED;
    txn(4'b0000, -1, -1);
    txn(4'b0010, -1, 4);
`endif

    repeat (20) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Full-period walk: one step per grant, every nonzero state exactly once.
  task automatic period_seq();
    bit          seen [8192];
    logic [12:0] m1;
    logic [12:0] first;
    int          t;
    bit          ok;
    m1    = SEED;
    first = '0;
    @(negedge clock);
    rst1 = 1'b0;
    req1 = 4'b0001;
    for (int g = 0; g <= 8191; g++) begin
      t = 0;
      @(negedge clock);
      while (gnt1 == 4'b0000 && t < 8) begin
        @(negedge clock);
        t++;
      end
      if (gnt1 == 4'b0000) begin
        chk("t5_gnt_timeout", 0, 1);
        break;
      end
      m1 = mstep(m1);
      if (g == 0) first = m1;
      if (g < 8191) begin
        ok = (rnd_out1 == m1) && !seen[rnd_out1] && (rnd_out1 != 13'h0);
        chk("t5_lfsr_period", ok, 1'b1);
        seen[rnd_out1] = 1'b1;
      end else begin
        chk("t5_wrap", rnd_out1, first);
      end
    end
    req1 = '0;
  endtask

  initial begin
    fork
      main_seq();
      period_seq();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
